// File: rtl/gray_seq_gen_pkg.sv
// Shared types and helpers for the Gray-code sequence generator.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Zero-extension leaves the top Gray bit equal to the top binary bit.
  function automatic logic [63:0] bin2gray(input logic [63:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_gen_enc.sv
// Combinational binary-to-Gray encoder feeding the output code register.
module bin2gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  logic [63:0] w_gray64;

  assign w_gray64 = bin2gray(64'(i_bin));
  assign o_gray   = w_gray64[WIDTH-1:0];

endmodule

// File: rtl/gray_seq_gen.sv
// Gray-code sequence generator: up/down binary counter on a valid/ready stream,
// with parallel load and wrap-or-finish behaviour at the terminal code.
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] G,
  output logic             G_valid,
  input  logic             G_ready,
  output logic             wrap,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_G;
  logic             r_wrap;

  state_t           w_nextState;
  logic [WIDTH-1:0] w_nextBin;
  logic [WIDTH-1:0] w_nextGray;
  logic             w_nextWrap;
  logic             w_xfer;
  logic             w_terminal;

  assign w_xfer     = (r_state == RUN) && G_ready;
  assign w_terminal = up_dn ? (r_bin == {WIDTH{1'b1}}) : (r_bin == '0);

  // A stop coinciding with a transfer lets the transfer complete before leaving RUN.
  always_comb begin
    w_nextState = r_state;
    w_nextBin   = r_bin;
    w_nextWrap  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) w_nextBin = load_val;
        if (start) w_nextState = RUN;
      end
      RUN: begin
        if (w_xfer) begin
          if (w_terminal) w_nextWrap = 1'b1;
          if (w_terminal && !WRAP) begin
            w_nextState = DONE;
          end else begin
            w_nextBin = up_dn ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1);
          end
        end
        if (stop) w_nextState = IDLE;
      end
      DONE: begin
        if (load) begin
          w_nextBin   = load_val;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
    .i_bin  (w_nextBin),
    .o_gray (w_nextGray)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_G     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_bin   <= w_nextBin;
      r_G     <= w_nextGray;
      r_wrap  <= w_nextWrap;
    end
  end

  assign G       = r_G;
  assign G_valid = (r_state == RUN);
  assign busy    = (r_state == RUN);
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Randomized and directed bench for gray_seq_gen; a wrapping and a finishing
// instance share inputs and are both compared against an arithmetic model.
module tb_gray_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       upDn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] loadVal = 8'h00;
  logic       gReady = 1'b0;

  logic [7:0] gOut   [2];
  logic       gValid [2];
  logic       wrapOut[2];
  logic       busyOut[2];

  int total = 0;
  int bad   = 0;

  // Model: mode 0 = idle, 1 = streaming, 2 = finished.
  int mBin [2];
  int mMode[2];
  int mWrap[2];

  always #5 clk = ~clk;

  gray_seq_gen #(.WIDTH(8), .WRAP(1'b1)) dutWrap (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(upDn),
    .load(load), .load_val(loadVal), .G(gOut[0]), .G_valid(gValid[0]),
    .G_ready(gReady), .wrap(wrapOut[0]), .busy(busyOut[0])
  );

  gray_seq_gen #(.WIDTH(8), .WRAP(1'b0)) dutStop (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(upDn),
    .load(load), .load_val(loadVal), .G(gOut[1]), .G_valid(gValid[1]),
    .G_ready(gReady), .wrap(wrapOut[1]), .busy(busyOut[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input int k, input bit wrapEn);
    bit term;
    if (rst) begin
      mBin[k] = 0; mMode[k] = 0; mWrap[k] = 0;
      return;
    end
    mWrap[k] = 0;
    if (mMode[k] == 0) begin
      if (load) mBin[k] = int'(loadVal);
      if (start) mMode[k] = 1;
    end else if (mMode[k] == 1) begin
      if (gReady) begin
        term = upDn ? (mBin[k] == 255) : (mBin[k] == 0);
        if (term) mWrap[k] = 1;
        if (term && !wrapEn) mMode[k] = 2;
        else mBin[k] = (mBin[k] + (upDn ? 1 : 255)) % 256;
      end
      if (stop) mMode[k] = 0;
    end else if (load) begin
      mBin[k] = int'(loadVal);
      mMode[k] = 0;
    end
  endtask

  task automatic tick();
    logic [7:0] prevA;
    bit         xferA;
    prevA = gOut[0];
    xferA = !rst && gValid[0] && gReady;
    @(posedge clk);
    modelStep(0, 1'b1);
    modelStep(1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("G[%0d]", k), 32'(gOut[k]),
                  32'((mBin[k] ^ (mBin[k] >> 1)) & 255));
      checkOutput($sformatf("G_valid[%0d]", k), 32'(gValid[k]), 32'(mMode[k] == 1));
      checkOutput($sformatf("busy[%0d]", k), 32'(busyOut[k]), 32'(mMode[k] == 1));
      checkOutput($sformatf("wrap[%0d]", k), 32'(wrapOut[k]), 32'(mWrap[k]));
    end
    if (xferA) checkOutput("hamming", 32'($countones(prevA ^ gOut[0])), 32'd1);
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic sp,
                               input logic ud, input logic ld, input logic [7:0] lv,
                               input logic rdy);
    rst = r; start = st; stop = sp; upDn = ud; load = ld; loadVal = lv; gReady = rdy;
    tick();
  endtask

  initial begin
    logic [7:0] lv;
    logic [7:0] edgeVals [4];
    edgeVals[0] = 8'h00; edgeVals[1] = 8'h01; edgeVals[2] = 8'hFE; edgeVals[3] = 8'hFF;

    @(negedge clk);
    applyStimulus(1, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("rst G", 32'(gOut[0]), 32'h00);
    checkOutput("rst valid", 32'(gValid[0]), 32'd0);

    // Load together with start begins streaming from the loaded value.
    applyStimulus(0, 1, 0, 1, 1, 8'h05, 0);
    checkOutput("t1 G0", 32'(gOut[0]), 32'h07);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t1 G1", 32'(gOut[0]), 32'h05);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t1 G2", 32'(gOut[0]), 32'h04);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t1 G3", 32'(gOut[0]), 32'h0C);

    applyStimulus(0, 0, 1, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 1, 1, 8'hFE, 0);
    checkOutput("t2 G0", 32'(gOut[0]), 32'h81);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t2 G1", 32'(gOut[0]), 32'h80);
    checkOutput("t2 wrap early", 32'(wrapOut[0]), 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t2 G2", 32'(gOut[0]), 32'h00);
    checkOutput("t2 wrap", 32'(wrapOut[0]), 32'd1);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t2 wrap once", 32'(wrapOut[0]), 32'd0);

    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 1, 8'h01, 0);
    checkOutput("t3 G0", 32'(gOut[1]), 32'h01);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("t3 G1", 32'(gOut[1]), 32'h00);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("t3 done G", 32'(gOut[1]), 32'h00);
    checkOutput("t3 done valid", 32'(gValid[1]), 32'd0);
    checkOutput("t3 done wrap", 32'(wrapOut[1]), 32'd1);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 1);
    checkOutput("t3 start ignored", 32'(gValid[1]), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 8'h10, 0);
    checkOutput("t3 reload G", 32'(gOut[1]), 32'h18);
    checkOutput("t3 reload valid", 32'(gValid[1]), 32'd0);

    // Backpressure: code must hold while up_dn wiggles.
    applyStimulus(1, 0, 0, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 1, 1, 8'h40, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, logic'(i % 2), 0, 8'h00, 0);
      checkOutput("t4 hold G", 32'(gOut[0]), 32'h60);
      checkOutput("t4 hold valid", 32'(gValid[0]), 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("t4 release G", 32'(gOut[0]), 32'h20);

    applyStimulus(1, 0, 0, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 1, 1, 8'h20, 0);
    applyStimulus(0, 0, 1, 1, 0, 8'h00, 1);
    checkOutput("t5 G", 32'(gOut[0]), 32'h31);
    checkOutput("t5 valid", 32'(gValid[0]), 32'd0);

    applyStimulus(0, 1, 0, 1, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    applyStimulus(1, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t6 G", 32'(gOut[0]), 32'h00);
    checkOutput("t6 busy", 32'(busyOut[0]), 32'd0);
    applyStimulus(0, 1, 0, 1, 0, 8'h00, 1);
    checkOutput("t6 G0", 32'(gOut[0]), 32'h00);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t6 G1", 32'(gOut[0]), 32'h01);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t6 G2", 32'(gOut[0]), 32'h03);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 1);
    checkOutput("t6 G3", 32'(gOut[0]), 32'h02);

    // Random traffic, biased toward terminal values so wrap/finish paths are hit.
    for (int i = 0; i < 600; i++) begin
      lv = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : 8'($urandom);
      applyStimulus(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 7) == 0), lv,
                    logic'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
